mem_port_arbiter: RTL

- Shares the single-port instruction/data memory between two requesters: the instruction-fetch path (IF) and the load/store path (D) of the multicycle CPU.
- Replaces hard-coded memory wait states in the control FSM with a req/done handshake.
- Drives memory address, MemReadWrite and write data; returns read data to the owning requester after a fixed MEM_LAT wait.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_wait_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/D single-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    localparam int MEM_LAT_DEFAULT = 3;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the memory access window; saturates at zero.
module mem_wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory between the fetch and load/store paths.
// Define MEM_ARB_RR_EN for round-robin tie breaking; the default is fixed D-over-IF priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        state_out
);

    localparam int             CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    arb_state_t state;
    arb_owner_t owner;
    logic       grant_d;
    logic       accept;
    logic       cnt_zero;

    assign accept    = (state == ARB_IDLE) && (if_req || d_req);
    assign state_out = state;

`ifdef MEM_ARB_RR_EN
    arb_owner_t last_owner;

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        grant_d = d_req;
        if (d_req && if_req) begin
            grant_d = (last_owner == OWN_IF);
        end
    end

    // Reset to D so that the very first tie goes to the fetch path.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_owner <= OWN_D;
        end else if (accept) begin
            last_owner <= grant_d ? OWN_D : OWN_IF;
        end
    end
`else
    assign grant_d = d_req;
`endif

    mem_wait_counter #(.CNT_W(CNT_W)) u_wait (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .load_val (LAT_M1),
        .dec      (state == ARB_ACCESS),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            owner     <= OWN_IF;
            mem_addr  <= '0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    mem_wr <= 1'b0;
                    if (accept) begin
                        state <= ARB_ACCESS;
                        busy  <= 1'b1;
                        if (grant_d) begin
                            owner     <= OWN_D;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_wr    <= d_we;
                        end else begin
                            owner    <= OWN_IF;
                            mem_addr <= if_addr;
                            mem_wr   <= 1'b0;
                        end
                    end
                end
                ARB_ACCESS: begin
                    // mem_wr doubles as the latched write-enable of the current owner.
                    if (cnt_zero) begin
                        state  <= ARB_RESP;
                        mem_wr <= 1'b0;
                        if (owner == OWN_D) begin
                            d_done <= 1'b1;
                            if (!mem_wr) d_rdata <= mem_rdata;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                ARB_RESP: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= ARB_IDLE;
                    busy   <= 1'b0;
                    mem_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule
